bp_fe_bp_resolve_queue: RTL and testbench
=========================================

Name: bp_fe_bp_resolve_queue

Overview:
- In-order tracker of outstanding branch predictions between the front-end and the gshare BHT.
- Records each issued prediction (BHT index, predicted direction) in a FIFO.
- When the backend resolves the oldest branch, it emits the update triple (write-valid, write-index, correct) that drives the BHT write port.
- Also keeps saturating resolve and mispredict statistics counters.

Parameters:
- bht_idx_width_p, 10, width of the BHT index carried per entry.
- depth_p, 8, FIFO entries. Power of two, ≥2.
- cnt_width_p, 16, width of the statistics counters.
- ptr_width_lp (local), $clog2(depth_p).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- pred_v_i  in  1  prediction issued this cycle.
- pred_idx_i  in  bht_idx_width_p  BHT index used for the prediction.
- pred_taken_i  in  1  predicted direction (the BHT predict output).
- pred_ready_o  out  1  queue can accept a prediction.
- res_v_i  in  1  backend resolves the oldest branch.
- res_taken_i  in  1  actual direction.
- res_ready_o  out  1  an unresolved entry exists.
- flush_i  in  1  discard all outstanding entries.
- w_v_o  out  1  BHT update valid.
- idx_w_o  out  bht_idx_width_p  BHT update index.
- correct_o  out  1  prediction matched outcome.
- count_o  out  ptr_width_lp+1  current occupancy.
- resolved_cnt_o  out  cnt_width_p  accepted resolutions, saturating.
- mispred_cnt_o  out  cnt_width_p  mispredicted resolutions, saturating.

Behaviour:
- Reset (asynchronous, reset_n_i=0), all values 0:
  - pointers, count_o, w_v_o, idx_w_o, correct_o, resolved_cnt_o, mispred_cnt_o.
  - Resulting outputs: pred_ready_o=1, res_ready_o=0.
- Handshake signals:
  - pred_ready_o = (count_o != depth_p). Does not depend on a same-cycle dequeue, so there is no full-bypass.
  - res_ready_o = (count_o != 0). No empty-bypass: a prediction and a resolution arriving on the same cycle into an empty queue accept only the enqueue.
- Enqueue: when pred_v_i & pred_ready_o, write {pred_idx_i, pred_taken_i} at the write pointer; the write pointer increments and wraps modulo depth_p.
- Dequeue: when res_v_i & res_ready_o, read the head entry; the read pointer increments and wraps.
  - Next cycle: w_v_o=1, idx_w_o=entry.idx, correct_o=(entry.taken == res_taken_i).
  - Update latency is exactly 1 cycle; outputs are registered.
- If no dequeue is accepted in a cycle, w_v_o=0 in the following cycle. idx_w_o and correct_o hold their previous values.
- Simultaneous enqueue and dequeue: both take effect and count_o is unchanged. This is legal at full only when pred_ready_o=1, i.e. never at full.
- Occupancy: count_o changes +1 on enqueue only, −1 on dequeue only, unchanged otherwise.
- Ignored inputs: pred_v_i while not ready and res_v_i while not ready are dropped silently with no state change. Issuing either is a protocol violation; assert in simulation.
- Flush:
  - flush_i has priority over enqueue and dequeue in the same cycle; both are ignored.
  - Next cycle: pointers = 0, count_o = 0, w_v_o = 0.
  - An update already registered from the previous cycle is not cancelled, because it is visible in the flush cycle itself.
  - Statistics counters are not cleared by flush.
- Statistics counters:
  - On each accepted dequeue, resolved_cnt_o increments; mispred_cnt_o also increments when the prediction was incorrect.
  - Both saturate at 2^cnt_width_p−1; they do not wrap.
- Reset mid-operation: asynchronous clear of everything above; in-flight entries are lost.

Decomposition:
- Shared package bp_fe_bp_pkg provides:
  - typedef bp_fe_bp_entry_s {idx[bht_idx_width_p-1:0], taken}, parameterised via macro.
  - localparam defaults for bht_idx_width and bp_cnt_sat_bits, shared with the gshare BHT.
- Sub-module bp_fe_bp_resolve_fifo: generic circular FIFO holding the entry storage, pointers, count, and full/empty logic.
- The top level adds the compare, the registered update, flush control, and the statistics counters.

Test Plan:
- Reset, then enqueue idx=0x12 taken=1, then resolve taken=1 → one cycle later w_v_o=1, idx_w_o=0x12, correct_o=1; resolved_cnt_o=1, mispred_cnt_o=0.
- Enqueue idx=0x3 taken=0, resolve taken=1 → w_v_o=1, idx_w_o=0x3, correct_o=0, mispred_cnt_o=1.
- Enqueue 8 entries idx=0..7 → pred_ready_o=0, count_o=8. A 9th pred_v_i is dropped. Resolve 8 → idx_w_o sequence 0..7 in order; the pointers wrap on subsequent enqueues with no data corruption.
- Empty queue with pred_v_i and res_v_i in the same cycle → only the enqueue is accepted, count_o=1, w_v_o=0 next cycle. At count 3, simultaneous enqueue and resolve → count_o stays 3.
- 4 entries queued, flush_i asserted together with pred_v_i and res_v_i → next cycle count_o=0, w_v_o=0, counters unchanged. A prior-cycle update still appears in the flush cycle.
- cnt_width_p=4: 20 mispredicted resolves → both counters stick at 15. Asserting reset_n_i=0 mid-stream → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_fe_bp_pkg.sv
// Shared branch-predictor front-end types and defaults.
// The resolve queue and the gshare BHT both use these.
`define BP_FE_BP_ENTRY_S(idx_width) struct packed { logic [(idx_width)-1:0] idx; logic taken; }

package bp_fe_bp_pkg;

  localparam int bht_idx_width_gp   = 10;
  localparam int bp_cnt_sat_bits_gp = 2;

  typedef `BP_FE_BP_ENTRY_S(bht_idx_width_gp) bp_fe_bp_entry_s;

endpackage

// File: rtl/bp_fe_bp_resolve_fifo.sv
// Generic circular FIFO with a synchronous clear.
// The head entry is presented combinationally; enqueues and dequeues self-guard on full/empty.
module bp_fe_bp_resolve_fifo #(
  parameter  int width_p      = 11,
  parameter  int depth_p      = 8,
  localparam int ptr_width_lp = $clog2(depth_p)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clear,
  input  logic                    i_enq,
  input  logic [width_p-1:0]      i_data,
  input  logic                    i_deq,
  output logic [width_p-1:0]      o_data,
  output logic [ptr_width_lp:0]   o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  logic [width_p-1:0]      r_mem [depth_p];
  logic [ptr_width_lp-1:0] r_wr_ptr;
  logic [ptr_width_lp-1:0] r_rd_ptr;
  logic [ptr_width_lp:0]   r_count;
  logic                    w_enq;
  logic                    w_deq;

  assign o_full  = (r_count == (ptr_width_lp+1)'(depth_p));
  assign o_empty = (r_count == '0);
  assign w_enq   = i_enq & ~o_full & ~i_clear;
  assign w_deq   = i_deq & ~o_empty & ~i_clear;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap for free because depth_p is a power of two.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + ptr_width_lp'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + ptr_width_lp'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (ptr_width_lp+1)'(1);
        2'b01:   r_count <= r_count - (ptr_width_lp+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_fe_bp_resolve_queue.sv
// In-order tracker of outstanding branch predictions; on resolution of the oldest
// branch it emits a registered BHT update and bumps saturating statistics.
module bp_fe_bp_resolve_queue
  import bp_fe_bp_pkg::*;
#(
  parameter  int bht_idx_width_p = bht_idx_width_gp,
  parameter  int depth_p         = 8,
  parameter  int cnt_width_p     = 16,
  localparam int ptr_width_lp    = $clog2(depth_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       res_ready_o,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [ptr_width_lp:0]      count_o,
  output logic [cnt_width_p-1:0]     resolved_cnt_o,
  output logic [cnt_width_p-1:0]     mispred_cnt_o
);

  typedef `BP_FE_BP_ENTRY_S(bht_idx_width_p) entry_s;

  entry_s                     w_enq_entry;
  entry_s                     w_head;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_enq;
  logic                       w_deq;
  logic                       w_correct;
  logic                       r_w_v;
  logic [bht_idx_width_p-1:0] r_idx_w;
  logic                       r_correct;
  logic [cnt_width_p-1:0]     r_resolved_cnt;
  logic [cnt_width_p-1:0]     r_mispred_cnt;

  assign pred_ready_o = ~w_full;
  assign res_ready_o  = ~w_empty;
  assign w_enq        = pred_v_i & pred_ready_o & ~flush_i;
  assign w_deq        = res_v_i & res_ready_o & ~flush_i;
  assign w_enq_entry  = '{idx: pred_idx_i, taken: pred_taken_i};
  assign w_correct    = (w_head.taken == res_taken_i);

  bp_fe_bp_resolve_fifo #(
    .width_p (bht_idx_width_p + 1),
    .depth_p (depth_p)
  ) u_fifo (
    .i_clk     (clk_i),
    .i_reset_n (reset_n_i),
    .i_clear   (flush_i),
    .i_enq     (w_enq),
    .i_data    (w_enq_entry),
    .i_deq     (w_deq),
    .o_data    (w_head),
    .o_count   (count_o),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Index and direction hold between updates; only the valid strobe drops.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_w_v     <= 1'b0;
      r_idx_w   <= '0;
      r_correct <= 1'b0;
    end else begin
      r_w_v <= w_deq;
      if (w_deq) begin
        r_idx_w   <= w_head.idx;
        r_correct <= w_correct;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_resolved_cnt <= '0;
      r_mispred_cnt  <= '0;
    end else if (w_deq) begin
      if (r_resolved_cnt != '1) begin
        r_resolved_cnt <= r_resolved_cnt + cnt_width_p'(1);
      end
      if (!w_correct && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + cnt_width_p'(1);
      end
    end
  end

  assign w_v_o          = r_w_v;
  assign idx_w_o        = r_idx_w;
  assign correct_o      = r_correct;
  assign resolved_cnt_o = r_resolved_cnt;
  assign mispred_cnt_o  = r_mispred_cnt;

  // Requests while not ready are dropped by the datapath; flag them for the integrator.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(pred_v_i && !pred_ready_o))
        else $warning("protocol: pred_v_i while queue full, prediction dropped");
      assert (!(res_v_i && !res_ready_o))
        else $warning("protocol: res_v_i while queue empty, resolution dropped");
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_resolve_queue.sv
// Self-checking bench for bp_fe_bp_resolve_queue: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_bp_fe_bp_resolve_queue;

  logic       clk = 1'b0;
  logic       resetN;
  logic       predV;
  logic [9:0] predIdx;
  logic       predTaken;
  logic       predReady;
  logic       resV;
  logic       resTaken;
  logic       resReady;
  logic       flush;
  logic       wV;
  logic [9:0] idxW;
  logic       correct;
  logic [3:0] count;
  logic [3:0] resolvedCnt;
  logic [3:0] mispredCnt;

  int checks = 0;
  int passes = 0;

  logic [10:0] mq[$];
  logic        mWv;
  logic [9:0]  mIdx;
  logic        mCorrect;
  int          mRes;
  int          mMis;

  bp_fe_bp_resolve_queue #(
    .bht_idx_width_p (10),
    .depth_p         (8),
    .cnt_width_p     (4)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (resetN),
    .pred_v_i       (predV),
    .pred_idx_i     (predIdx),
    .pred_taken_i   (predTaken),
    .pred_ready_o   (predReady),
    .res_v_i        (resV),
    .res_taken_i    (resTaken),
    .res_ready_o    (resReady),
    .flush_i        (flush),
    .w_v_o          (wV),
    .idx_w_o        (idxW),
    .correct_o      (correct),
    .count_o        (count),
    .resolved_cnt_o (resolvedCnt),
    .mispred_cnt_o  (mispredCnt)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mq.delete();
    mWv      = 1'b0;
    mIdx     = '0;
    mCorrect = 1'b0;
    mRes     = 0;
    mMis     = 0;
  endtask

  // Drives one cycle of inputs, advances the model by the same cycle, returns #1 after the edge.
  task automatic cycle(input logic pv, input logic [9:0] pidx, input logic pt,
                       input logic rv, input logic rt, input logic fl);
    bit          doEnq;
    bit          doDeq;
    logic [10:0] head;
    predV     = pv;
    predIdx   = pidx;
    predTaken = pt;
    resV      = rv;
    resTaken  = rt;
    flush     = fl;
    doEnq = pv && (mq.size() != 8) && !fl;
    doDeq = rv && (mq.size() != 0) && !fl;
    mWv   = doDeq;
    if (doDeq) begin
      head     = mq.pop_front();
      mIdx     = head[10:1];
      mCorrect = (head[0] == rt);
      if (mRes < 15) mRes++;
      if (!mCorrect && mMis < 15) mMis++;
    end
    if (doEnq) mq.push_back({pidx, pt});
    if (fl) mq.delete();
    @(posedge clk);
    #1;
    predV = 1'b0;
    resV  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    predV = 0; predIdx = 0; predTaken = 0; resV = 0; resTaken = 0; flush = 0;
    modelReset();
    #11;
    checks++; if (count !== 4'd0) $display("[TB] FAIL reset count: got %0d want 0", count); else passes++;
    checks++; if (predReady !== 1'b1) $display("[TB] FAIL reset predReady: got %b want 1", predReady); else passes++;
    checks++; if (resReady !== 1'b0) $display("[TB] FAIL reset resReady: got %b want 0", resReady); else passes++;
    checks++; if (wV !== 1'b0) $display("[TB] FAIL reset wV: got %b want 0", wV); else passes++;
    checks++; if (idxW !== 10'd0 || correct !== 1'b0) $display("[TB] FAIL reset update: got idx=%h correct=%b want 0/0", idxW, correct); else passes++;
    checks++; if (resolvedCnt !== 4'd0 || mispredCnt !== 4'd0) $display("[TB] FAIL reset stats: got %0d/%0d want 0/0", resolvedCnt, mispredCnt); else passes++;
    resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    cycle(1'b1, 10'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 4'd1 || resReady !== 1'b1) $display("[TB] FAIL basic enq: got count=%0d resReady=%b want 1/1", count, resReady); else passes++;
    cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (wV !== 1'b1 || idxW !== 10'h12 || correct !== 1'b1) $display("[TB] FAIL basic hit update: got v=%b idx=%h c=%b want 1/12/1", wV, idxW, correct); else passes++;
    checks++; if (resolvedCnt !== 4'd1 || mispredCnt !== 4'd0) $display("[TB] FAIL basic hit stats: got %0d/%0d want 1/0", resolvedCnt, mispredCnt); else passes++;
    cycle(1'b1, 10'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (wV !== 1'b0 || idxW !== 10'h12) $display("[TB] FAIL basic idle hold: got v=%b idx=%h want 0/12", wV, idxW); else passes++;
    cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (wV !== 1'b1 || idxW !== 10'h3 || correct !== 1'b0) $display("[TB] FAIL basic miss update: got v=%b idx=%h c=%b want 1/3/0", wV, idxW, correct); else passes++;
    checks++; if (resolvedCnt !== 4'd2 || mispredCnt !== 4'd1) $display("[TB] FAIL basic miss stats: got %0d/%0d want 2/1", resolvedCnt, mispredCnt); else passes++;
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 8; i++) cycle(1'b1, 10'(i), i[0], 1'b0, 1'b0, 1'b0);
    checks++; if (predReady !== 1'b0 || count !== 4'd8) $display("[TB] FAIL full state: got ready=%b count=%0d want 0/8", predReady, count); else passes++;
    cycle(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 4'd8) $display("[TB] FAIL full drop: got count=%0d want 8", count); else passes++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++; if (wV !== 1'b1 || idxW !== 10'(i) || correct !== i[0]) $display("[TB] FAIL full drain %0d: got v=%b idx=%h c=%b want 1/%h/%b", i, wV, idxW, correct, i, i[0]); else passes++;
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 10'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (idxW !== 10'(100 + i) || correct !== 1'b1) $display("[TB] FAIL wrap %0d: got idx=%0d c=%b want %0d/1", i, idxW, correct, 100 + i); else passes++;
    end
    checks++; if (count !== 4'd0 || resReady !== 1'b0) $display("[TB] FAIL wrap empty: got count=%0d resReady=%b want 0/0", count, resReady); else passes++;
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 10'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd1) $display("[TB] FAIL sim empty count: got %0d want 1", count); else passes++;
    cycle(1'b1, 10'h56, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (wV !== 1'b0) $display("[TB] FAIL sim empty wV: got %b want 0", wV); else passes++;
    cycle(1'b1, 10'h57, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 10'h66, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (count !== 4'd3) $display("[TB] FAIL sim count3: got %0d want 3", count); else passes++;
    checks++; if (wV !== 1'b1 || idxW !== 10'h55 || correct !== 1'b1) $display("[TB] FAIL sim update: got v=%b idx=%h c=%b want 1/55/1", wV, idxW, correct); else passes++;
  endtask

  task automatic test_flush();
    logic [3:0] savedRes;
    logic [3:0] savedMis;
    cycle(1'b1, 10'h70, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 10'h71, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd4) $display("[TB] FAIL flush setup count: got %0d want 4", count); else passes++;
    checks++; if (wV !== 1'b1 || idxW !== 10'h56) $display("[TB] FAIL flush prior update: got v=%b idx=%h want 1/56", wV, idxW); else passes++;
    savedRes = resolvedCnt;
    savedMis = mispredCnt;
    cycle(1'b1, 10'h99, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (count !== 4'd0 || wV !== 1'b0) $display("[TB] FAIL flush result: got count=%0d v=%b want 0/0", count, wV); else passes++;
    checks++; if (resolvedCnt !== savedRes || mispredCnt !== savedMis || resolvedCnt !== 4'(mRes)) $display("[TB] FAIL flush stats: got %0d/%0d want %0d/%0d", resolvedCnt, mispredCnt, mRes, mMis); else passes++;
    cycle(1'b1, 10'h2A, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (wV !== 1'b1 || idxW !== 10'h2A || count !== 4'd0) $display("[TB] FAIL flush recover: got v=%b idx=%h count=%0d want 1/2a/0", wV, idxW, count); else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic pv;
      logic rv;
      logic fl;
      pv = ($urandom_range(0, 99) < 60) && (mq.size() != 8);
      rv = ($urandom_range(0, 99) < 50) && (mq.size() != 0);
      fl = ($urandom_range(0, 99) < 4);
      cycle(pv, 10'($urandom_range(0, 1023)), 1'($urandom), rv, 1'($urandom), fl);
      checks++;
      if (wV !== mWv || count !== 4'(mq.size()) || resolvedCnt !== 4'(mRes) || mispredCnt !== 4'(mMis)
          || predReady !== (mq.size() != 8) || resReady !== (mq.size() != 0)
          || (mWv && (idxW !== mIdx || correct !== mCorrect)))
        $display("[TB] FAIL random cyc %0d: got v=%b idx=%h c=%b cnt=%0d st=%0d/%0d want v=%b idx=%h c=%b cnt=%0d st=%0d/%0d",
                 n, wV, idxW, correct, count, resolvedCnt, mispredCnt, mWv, mIdx, mCorrect, mq.size(), mRes, mMis);
      else passes++;
    end
    while (mq.size() != 0) cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    cycle(1'b1, 10'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 10'(i + 2), 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (resolvedCnt !== 4'd15 || mispredCnt !== 4'd15) $display("[TB] FAIL saturation: got %0d/%0d want 15/15", resolvedCnt, mispredCnt); else passes++;
    checks++; if (count !== 4'd1 || correct !== 1'b0 || idxW !== 10'd20) $display("[TB] FAIL saturation tail: got count=%0d c=%b idx=%0d want 1/0/20", count, correct, idxW); else passes++;
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 10'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (wV !== 1'b1 || count === 4'd0) $display("[TB] FAIL areset setup: got v=%b count=%0d want 1/nonzero", wV, count); else passes++;
    resetN = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || wV !== 1'b0 || idxW !== 10'd0 || correct !== 1'b0) $display("[TB] FAIL areset outputs: got count=%0d v=%b idx=%h c=%b want 0/0/0/0", count, wV, idxW, correct); else passes++;
    checks++; if (resolvedCnt !== 4'd0 || mispredCnt !== 4'd0 || predReady !== 1'b1 || resReady !== 1'b0) $display("[TB] FAIL areset stats: got %0d/%0d rdy=%b/%b want 0/0 1/0", resolvedCnt, mispredCnt, predReady, resReady); else passes++;
    #1;
    resetN = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    cycle(1'b1, 10'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (wV !== 1'b1 || idxW !== 10'h77 || resolvedCnt !== 4'd1 || count !== 4'd0) $display("[TB] FAIL areset recover: got v=%b idx=%h res=%0d count=%0d want 1/77/1/0", wV, idxW, resolvedCnt, count); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_simultaneous();
    test_flush();
    test_random();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
